seq_divider_16: RTL

//  Iterative unsigned restoring divider: the inverse of the add path. It uses
//  one trial subtraction per cycle (A + ~B + 1 through a carry chain) to form

---
 rtl/seq_divider_16.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seq_divider_16.sv
// seq_divider_16: iterative unsigned restoring divider, one quotient bit per clock.
// Latency: WIDTH+1 edges from accepted start to done (2 edges for a zero divisor).
// Backpressure: start is ignored while busy; results are held until the next accepted start.
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   start, dividend, divisor request and operands, captured on an accepted start
//   busy, done              busy while iterating; done pulses one cycle with valid results
//   quotient, remainder     results, updated only on entry to DONE
//   div_by_zero             set with done when the captured divisor was zero
module seq_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  // ZDIV is a one-cycle staging state for a zero divisor: it keeps the
  // done timing at two edges after start without ever raising busy.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZDIV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    count;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] r_shift;
  logic             r_carry;
  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_iter = (count == CW'(1));

  // Shift {R,Q} left by one. The bit shifted out of R (r_carry) means the
  // shifted partial remainder is >= 2^WIDTH, hence >= D, so the subtract
  // must be taken regardless of the borrow. In that case the true difference
  // is below D and the low WIDTH bits of the trial are exact.
  assign r_carry = r_acc[WIDTH-1];
  assign r_shift = {r_acc[WIDTH-2:0], q_acc[WIDTH-1]};
  assign trial   = {1'b0, r_shift} + {1'b0, ~d_reg} + {{WIDTH{1'b0}}, 1'b1};
  // trial[WIDTH] is the carry out of A + ~B + 1: set means no borrow.
  assign take    = r_carry | trial[WIDTH];
  assign r_next  = take ? trial[WIDTH-1:0] : r_shift;
  assign q_next  = {q_acc[WIDTH-2:0], take};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? ZDIV : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      ZDIV: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      q_acc       <= '0;
      d_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_reg       <= divisor;
      r_acc       <= '0;
      q_acc       <= dividend;
      count       <= CW'(WIDTH);
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      r_acc <= r_next;
      q_acc <= q_next;
      count <= count - CW'(1);
      if (last_iter) begin
        quotient  <= q_next;
        remainder <= r_next;
      end
    end else if (state == ZDIV) begin
      // q_acc still holds the captured dividend.
      quotient    <= '1;
      remainder   <= q_acc;
      div_by_zero <= 1'b1;
    end
  end

endmodule
